// File: rtl/xor_share_arb_pkg.sv
// rtl/xor_share_arb_pkg.sv - shared defaults, ID width helper and response-register ops
package xor_share_arb_pkg;

  localparam int NREQ_DEFAULT  = 4;
  localparam int WIDTH_DEFAULT = 8;

  localparam logic ST_EMPTY = 1'b0;
  localparam logic ST_FULL  = 1'b1;

  typedef enum logic [1:0] {
    OP_HOLD    = 2'd0,
    OP_CAPTURE = 2'd1,
    OP_DRAIN   = 2'd2
  } rsp_op_e;

  // Requester ID width; clamped to 1 so a degenerate NREQ still yields a legal vector.
  function automatic int idw_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/xor_share_arb_rr_arbiter.sv
// rtl/xor_share_arb_rr_arbiter.sv - round-robin one-hot arbiter via double-width masked priority encode
module xor_share_arb_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx
);

  logic [2*NREQ-1:0] dbl;
  logic              found;

  assign dbl = {req, req};

  // Bits below ptr in the lower copy are masked; the upper copy supplies the wrap.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < 2 * NREQ; i++) begin
      if (!found && (i >= int'(ptr)) && dbl[i]) begin
        found = 1'b1;
        grant[i % NREQ] = en;
        idx = IDW'(i % NREQ);
      end
    end
  end

endmodule

// File: rtl/xor_share_arb.sv
// rtl/xor_share_arb.sv - shared registered XOR unit arbitrated round-robin among NREQ requesters
module xor_share_arb
  import xor_share_arb_pkg::*;
#(
  parameter int NREQ  = NREQ_DEFAULT,
  parameter int WIDTH = WIDTH_DEFAULT,
  localparam int IDW  = idw_of(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_y,
  output logic [IDW-1:0]        rsp_id
);

  logic             state;
  logic [IDW-1:0]   ptr;
  logic             accept;
  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   grant_idx;
  logic [WIDTH-1:0] sel_y;
  rsp_op_e          op;

  assign rsp_valid = state;
  assign accept    = (state == ST_EMPTY) | rsp_ready;

  xor_share_arb_rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .en    (accept),
    .grant (grant),
    .idx   (grant_idx)
  );

  assign req_ready = grant;

  // AND-OR select keyed by the one-hot grant so unselected operands never propagate.
  always_comb begin
    sel_y = '0;
    for (int i = 0; i < NREQ; i++) begin
      sel_y = sel_y | ((req_a[i*WIDTH +: WIDTH] ^ req_b[i*WIDTH +: WIDTH]) & {WIDTH{grant[i]}});
    end
  end

  always_comb begin
    op = OP_HOLD;
    if (accept) begin
      op = (|req_valid) ? OP_CAPTURE : OP_DRAIN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_EMPTY;
      rsp_y  <= '0;
      rsp_id <= '0;
      ptr    <= '0;
    end else begin
      case (op)
        OP_CAPTURE: begin
          state  <= ST_FULL;
          rsp_y  <= sel_y;
          rsp_id <= grant_idx;
          ptr    <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
        end
        OP_DRAIN: begin
          state <= ST_EMPTY;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xor_share_arb.sv
// tb/tb_xor_share_arb.sv - vector table, directed corner sequences and randomized scoreboard check
module tb_xor_share_arb;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_y;
  logic [1:0]  rsp_id;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  xor_share_arb #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_y     (rsp_y),
    .rsp_id    (rsp_id)
  );

  typedef struct {
    logic [3:0] rv;
    logic [3:0] exp_ready;
    logic       exp_vld;
    logic [7:0] exp_y;
    logic [1:0] exp_id;
  } vec_t;

  vec_t vecs[10];

  // Fixed operands: y0=33, y1=AA, y2=A5, y3=FF
  localparam logic [31:0] OPA = 32'hC3_5A_A5_11;
  localparam logic [31:0] OPB = 32'h3C_FF_0F_22;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input string name, input logic [3:0] rv, input logic rr,
                      input logic [3:0] exp_ready, input logic exp_vld,
                      input logic [7:0] exp_y, input logic [1:0] exp_id);
    @(negedge clk);
    req_valid = rv;
    rsp_ready = rr;
    #1;
    chk({name, ".req_ready"}, 32'(req_ready), 32'(exp_ready));
    @(posedge clk);
    #1;
    chk({name, ".rsp_valid"}, 32'(rsp_valid), 32'(exp_vld));
    chk({name, ".rsp_y"}, 32'(rsp_y), 32'(exp_y));
    chk({name, ".rsp_id"}, 32'(rsp_id), 32'(exp_id));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [9:0] q[$];
  int         mptr;
  logic [7:0] ra [4];
  logic [7:0] rb [4];

  initial begin
    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    req_a = OPA;
    req_b = OPB;

    vecs[0] = '{4'b0010, 4'b0010, 1'b1, 8'hAA, 2'd1};
    vecs[1] = '{4'b1111, 4'b0100, 1'b1, 8'hA5, 2'd2};
    vecs[2] = '{4'b1111, 4'b1000, 1'b1, 8'hFF, 2'd3};
    vecs[3] = '{4'b1111, 4'b0001, 1'b1, 8'h33, 2'd0};
    vecs[4] = '{4'b1111, 4'b0010, 1'b1, 8'hAA, 2'd1};
    vecs[5] = '{4'b1001, 4'b1000, 1'b1, 8'hFF, 2'd3};
    vecs[6] = '{4'b1001, 4'b0001, 1'b1, 8'h33, 2'd0};
    vecs[7] = '{4'b1001, 4'b1000, 1'b1, 8'hFF, 2'd3};
    vecs[8] = '{4'b0000, 4'b0000, 1'b0, 8'hFF, 2'd3};
    vecs[9] = '{4'b0001, 4'b0001, 1'b1, 8'h33, 2'd0};

    repeat (2) @(negedge clk);
    chk("reset.rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset.rsp_y", 32'(rsp_y), 32'h0);
    chk("reset.rsp_id", 32'(rsp_id), 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      step($sformatf("vec%0d", i), vecs[i].rv, 1'b1, vecs[i].exp_ready,
           vecs[i].exp_vld, vecs[i].exp_y, vecs[i].exp_id);
    end

    // Backpressure: hold FF/3 while consumer stalls, then grant req 2 on release
    step("bp_load", 4'b1000, 1'b1, 4'b1000, 1'b1, 8'hFF, 2'd3);
    for (int i = 0; i < 3; i++) begin
      step($sformatf("bp_stall%0d", i), 4'b0100, 1'b0, 4'b0000, 1'b1, 8'hFF, 2'd3);
    end
    step("bp_release", 4'b0100, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2);

    // Drain to empty keeps ptr at 3
    step("drain", 4'b0000, 1'b1, 4'b0000, 1'b0, 8'hA5, 2'd2);
    step("after_drain", 4'b1111, 1'b1, 4'b1000, 1'b1, 8'hFF, 2'd3);

    // Asynchronous reset while FULL
    @(negedge clk);
    req_valid = '0;
    rsp_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst.rsp_valid", 32'(rsp_valid), 32'h0);
    chk("async_rst.rsp_y", 32'(rsp_y), 32'h0);
    chk("async_rst.rsp_id", 32'(rsp_id), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst0", 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0);
    step("post_rst1", 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0);
    step("post_rst_ptr", 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h33, 2'd0);

    // Randomized traffic against a queue-based reference model
    do_reset();
    mptr = 0;
    q.delete();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      logic [3:0] rv;
      logic       rr;
      logic       full;
      logic       acc;
      logic [3:0] exp_ready;
      int         g;
      @(negedge clk);
      rv = 4'($urandom);
      rr = ($urandom % 4) != 0;
      req_a = $urandom;
      req_b = $urandom;
      req_valid = rv;
      rsp_ready = rr;
      for (int i = 0; i < 4; i++) begin
        ra[i] = req_a[i*8 +: 8];
        rb[i] = req_b[i*8 +: 8];
      end
      #1;
      full = q.size() != 0;
      chk("rand.rsp_valid", 32'(rsp_valid), 32'(full));
      if (full && rr) begin
        chk("rand.rsp_y", 32'(rsp_y), 32'(q[0][7:0]));
        chk("rand.rsp_id", 32'(rsp_id), 32'(q[0][9:8]));
        void'(q.pop_front());
      end
      acc = !full || rr;
      g = -1;
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (mptr + k) % NREQ;
        if (g < 0 && rv[i]) g = i;
      end
      exp_ready = '0;
      if (acc && g >= 0) begin
        exp_ready[g] = 1'b1;
        q.push_back({2'(g), ra[g] ^ rb[g]});
        mptr = (g + 1) % NREQ;
      end
      chk("rand.req_ready", 32'(req_ready), 32'(exp_ready));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
